// File: rtl/pacman_pixel_writer_if.sv
// Framebuffer write-port bundle between the pixel writer and the on-chip
// framebuffer. The writer is the master; the framebuffer stalls via waitrequest.
interface pacman_pixel_writer_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] fb_addr;
  logic [3:0]        fb_wrdata;
  logic              fb_write;
  logic              fb_waitrequest;

  modport master (
    output fb_addr,
    output fb_wrdata,
    output fb_write,
    input  fb_waitrequest
  );

  modport slave (
    input  fb_addr,
    input  fb_wrdata,
    input  fb_write,
    output fb_waitrequest
  );
endinterface

// File: rtl/pacman_pixel_writer.sv
// Pixel writer: decodes a packed draw command taken from the pixel_color PIO
// word and issues single-pixel or horizontal-run writes into the framebuffer.
// A new command is recognised by its toggle bit differing from the last one
// accepted; completion is signalled by inverting done_tog.
//
// cmd_in layout: [31] toggle, [30] run mode, [29:20] x, [19:11] y,
//                [10:4] run length minus 1, [3:0] colour index.
module pacman_pixel_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            cmd_in,
  pacman_pixel_writer_if.master  fb,
  output logic                   busy,
  output logic                   done_tog,
  output logic [7:0]             drop_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [31:0]       cmd_q;
  logic              last_tog;
  logic [9:0]        x_q;
  logic [8:0]        y_q;
  logic [3:0]        colour_q;
  logic [6:0]        remaining;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wrdata_q;
  logic              write_q;

  logic [ADDR_W-1:0] addr_calc;
  logic              out_of_range;
  logic              last_pixel;
  logic              accepted;

  // Row-major word address y*H_RES + x; the default 640-wide screen is
  // 512+128, so it reduces to two shifts and an add.
  generate
    if (H_RES == 640) begin : g_shift_add
      assign addr_calc = ADDR_W'({y_q, 9'd0}) + ADDR_W'({y_q, 7'd0}) + ADDR_W'(x_q);
    end else begin : g_multiply
      assign addr_calc = ADDR_W'(32'(y_q) * 32'(H_RES) + 32'(x_q));
    end
  endgenerate

  // Range, end-of-run and handshake decode for the current command.
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the stale value.
  always_comb begin
    out_of_range = (32'(x_q) >= 32'(H_RES)) || (32'(y_q) >= 32'(V_RES));
    last_pixel   = (remaining == 7'd0) || (32'(x_q) == 32'(H_RES - 1));
    accepted     = write_q && !fb.fb_waitrequest;
  end

  // Command capture, address generation and write sequencing.
  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      last_tog   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      remaining  <= '0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      write_q    <= 1'b0;
      busy       <= 1'b0;
      done_tog   <= 1'b0;
      drop_count <= '0;
    end else begin
      // The PIO word is sampled every cycle; only IDLE looks at it.
      cmd_q <= cmd_in;

      case (state)
        IDLE: begin
          if (cmd_q[31] != last_tog) begin
            x_q       <= cmd_q[29:20];
            y_q       <= cmd_q[19:11];
            colour_q  <= cmd_q[3:0];
            remaining <= cmd_q[30] ? cmd_q[10:4] : 7'd0;
            last_tog  <= cmd_q[31];
            busy      <= 1'b1;
            state     <= CALC;
          end
        end

        CALC: begin
          if (out_of_range) begin
            if (drop_count != 8'hFF) begin
              drop_count <= drop_count + 8'd1;
            end
            state <= DONE;
          end else begin
            addr_q   <= addr_calc;
            wrdata_q <= colour_q;
            write_q  <= 1'b1;
            state    <= WRITE;
          end
        end

        WRITE: begin
          // Address, data and strobe simply hold while the framebuffer stalls.
          if (accepted) begin
            if (last_pixel) begin
              // Runs stop at the right edge instead of wrapping to the next row.
              write_q <= 1'b0;
              state   <= DONE;
            end else begin
              x_q       <= x_q + 10'd1;
              addr_q    <= addr_q + ADDR_W'(1);
              remaining <= remaining - 7'd1;
            end
          end
        end

        DONE: begin
          done_tog <= ~done_tog;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          write_q <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign fb.fb_addr   = addr_q;
  assign fb.fb_wrdata = wrdata_q;
  assign fb.fb_write  = write_q;

endmodule
